// File: rtl/kbd_pkg.sv
// Shared PS/2 Set 2 keyboard definitions: decoder FSM states, protocol prefix bytes
// and the default make codes for the keys the character controller uses.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } kbd_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK     = 8'hAA;

  localparam logic [7:0] KBD_CODE_SPACE = 8'h29;
  localparam logic [7:0] KBD_CODE_LEFT  = 8'h6B;
  localparam logic [7:0] KBD_CODE_RIGHT = 8'h74;

endpackage

// File: rtl/ps2_key_decoder.sv
// Turns the PS/2 Set 2 byte stream into level-held Space/Left/Right flags, with a
// timeout that abandons a prefix (E0/F0) whose follow-up byte never arrives.
module ps2_key_decoder
  import kbd_pkg::*;
#(
  parameter logic [7:0] CODE_SPACE     = KBD_CODE_SPACE,
  parameter logic [7:0] CODE_LEFT      = KBD_CODE_LEFT,
  parameter logic [7:0] CODE_RIGHT     = KBD_CODE_RIGHT,
  parameter int         TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right,
  output logic       seq_error
);

  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT_CYCLES - 1);

  kbd_state_t    r_state;
  logic [CW-1:0] r_cnt;

  // NOTE: all state here is sequential, so every assignment is non-blocking (<=);
  // blocking assignments would make later reads see this cycle's new values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      key_space <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      seq_error <= 1'b0;
      if (rx_valid) begin
        // An accepted byte always wins over a timeout expiring in the same cycle.
        r_cnt <= '0;
        unique case (r_state)
          IDLE: begin
            if (rx_data == PS2_PREFIX_EXT)      r_state <= EXT;
            else if (rx_data == PS2_PREFIX_BRK) r_state <= BRK;
            else if (rx_data == CODE_SPACE)     key_space <= 1'b1;
          end
          EXT: begin
            if (rx_data == PS2_PREFIX_BRK) begin
              r_state <= EXT_BRK;
            end else if (rx_data == CODE_LEFT) begin
              key_left <= 1'b1;
              r_state  <= IDLE;
            end else if (rx_data == CODE_RIGHT) begin
              key_right <= 1'b1;
              r_state   <= IDLE;
            end else if (rx_data == PS2_PREFIX_EXT) begin
              r_state <= EXT;
            end else begin
              r_state <= IDLE;
            end
          end
          BRK: begin
            if (rx_data == CODE_SPACE) begin
              key_space <= 1'b0;
              r_state   <= IDLE;
            end else if (rx_data == PS2_PREFIX_EXT) begin
              r_state <= EXT;
            end else begin
              r_state <= IDLE;
            end
          end
          EXT_BRK: begin
            if (rx_data == CODE_LEFT)       key_left  <= 1'b0;
            else if (rx_data == CODE_RIGHT) key_right <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE) begin
        if (r_cnt == LP_LAST) begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          seq_error <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: hand-computed vector table, timeout/reset corner
// sequences, and random bytes checked against a sequence-level reference model.
module tb_ps2_key_decoder;
  import kbd_pkg::*;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       key_space, key_left, key_right, seq_error;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .key_space (key_space),
    .key_left  (key_left),
    .key_right (key_right),
    .seq_error (seq_error)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {space,left,right,err}=%b want %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] dut_out();
    return {key_space, key_left, key_right, seq_error};
  endfunction

  // Reference model: the pending prefix is kept as a byte string and each new byte
  // is matched against the complete sequences of the key set.
  logic        m_space, m_left, m_right, m_err;
  logic [23:0] m_pre;
  int          m_len;
  int          m_wait;

  function automatic void model_reset();
    m_space = 0; m_left = 0; m_right = 0; m_err = 0;
    m_pre = '0; m_len = 0; m_wait = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [23:0] s;
    int          n;
    s = {m_pre[15:0], b};
    n = m_len + 1;
    m_wait = 0;
    if      (n == 1 && s[7:0]  == 8'h29)      begin m_space = 1; m_len = 0; end
    else if (n == 2 && s[15:0] == 16'hF029)   begin m_space = 0; m_len = 0; end
    else if (n == 2 && s[15:0] == 16'hE06B)   begin m_left  = 1; m_len = 0; end
    else if (n == 2 && s[15:0] == 16'hE074)   begin m_right = 1; m_len = 0; end
    else if (n == 3 && s == 24'hE0F06B)       begin m_left  = 0; m_len = 0; end
    else if (n == 3 && s == 24'hE0F074)       begin m_right = 0; m_len = 0; end
    else if ((n == 1 && (b == 8'hE0 || b == 8'hF0)) || (n == 2 && s[15:0] == 16'hE0F0)) begin
      m_pre = s; m_len = n;
    end else if (b == 8'hE0 && m_len < 2) begin
      m_pre = 24'hE0; m_len = 1;
    end else begin
      m_len = 0;
    end
  endfunction

  function automatic void model_cycle(input logic v, input logic [7:0] b);
    m_err = 0;
    if (v) model_byte(b);
    else if (m_len != 0) begin
      if (m_wait == T - 1) begin m_err = 1; m_len = 0; m_wait = 0; end
      else m_wait++;
    end
  endfunction

  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_data  = b;
    model_cycle(v, b);
    @(posedge clk);
    #1;
    check("model", dut_out(), {m_space, m_left, m_right, m_err});
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] e;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [7:0] d, input logic [3:0] e);
    vec_t x;
    x.v = v; x.d = d; x.e = e;
    tbl.push_back(x);
  endfunction

  int err_seen;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_state", dut_out(), 4'b0000);
    @(negedge clk) rst = 1'b0;

    // Expected {space,left,right,err} after each byte, worked out by hand.
    add(1, 8'h29, 4'b1000); add(1, 8'hF0, 4'b1000); add(1, 8'h29, 4'b0000);
    add(1, 8'hE0, 4'b0000); add(1, 8'h6B, 4'b0100);
    add(1, 8'hE0, 4'b0100); add(1, 8'h74, 4'b0110);
    add(1, 8'hE0, 4'b0110); add(1, 8'hF0, 4'b0110); add(1, 8'h6B, 4'b0010);
    add(1, 8'hE0, 4'b0010); add(1, 8'hF0, 4'b0010); add(1, 8'h74, 4'b0000);
    add(1, 8'h6B, 4'b0000); add(1, 8'h74, 4'b0000);
    add(1, PS2_BAT_OK, 4'b0000); add(1, 8'hFA, 4'b0000);
    add(1, 8'hE0, 4'b0000); add(1, 8'h12, 4'b0000);
    add(0, 8'h29, 4'b0000);
    add(1, 8'h29, 4'b1000);
    for (int i = 0; i < 10; i++) add(1, 8'h29, 4'b1000);
    add(1, 8'hF0, 4'b1000); add(1, 8'h29, 4'b0000);
    add(1, 8'hF0, 4'b0000); add(1, 8'hE0, 4'b0000); add(1, 8'h6B, 4'b0100);
    add(1, 8'hE0, 4'b0100); add(1, 8'hF0, 4'b0100); add(1, 8'hE0, 4'b0100);
    add(1, 8'h6B, 4'b0100);
    add(1, 8'hE0, 4'b0100); add(1, 8'hF0, 4'b0100); add(1, 8'h6B, 4'b0000);
    add(1, 8'hE0, 4'b0000); add(1, 8'hE0, 4'b0000); add(1, 8'h74, 4'b0010);
    add(1, 8'hE0, 4'b0010); add(1, 8'hF0, 4'b0010); add(1, 8'h74, 4'b0000);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d);
      check($sformatf("vec%0d", i), dut_out(), tbl[i].e);
    end

    // Abandoned E0: exactly one error pulse, on the T-th idle cycle.
    step(1, 8'hE0);
    err_seen = 0;
    for (int i = 0; i < T; i++) begin
      step(0, 8'h00);
      if (seq_error) err_seen++;
      if (i == T - 1) check("timeout_fire", dut_out(), 4'b0001);
    end
    check("timeout_once", 4'(err_seen), 4'd1);
    step(0, 8'h00);
    check("timeout_after", dut_out(), 4'b0000);
    step(1, 8'h6B);
    check("stale_left", dut_out(), 4'b0000);

    // Follow-up byte lands on the expiry cycle: processed, no pulse.
    step(1, 8'hE0);
    for (int i = 0; i < T - 1; i++) step(0, 8'h00);
    step(1, 8'h6B);
    check("expiry_byte", dut_out(), 4'b0100);

    // Asynchronous reset in the middle of E0,F0 with key_left held.
    step(1, 8'hE0);
    step(1, 8'hF0);
    check("pre_reset", dut_out(), 4'b0100);
    #2 rst = 1'b1;
    #1 check("async_reset", dut_out(), 4'b0000);
    model_reset();
    @(negedge clk) rst = 1'b0;
    step(1, 8'h6B);
    check("post_reset_6b", dut_out(), 4'b0000);

    // Random byte streams with occasional idle gaps long enough to time out.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < int'($urandom_range(T - 3, T + 4)); k++) step(0, 8'h00);
      end else begin
        logic [7:0] b;
        case ($urandom_range(0, 7))
          0, 1:    b = 8'hE0;
          2:       b = 8'hF0;
          3:       b = 8'h29;
          4:       b = 8'h6B;
          5:       b = 8'h74;
          6:       b = 8'h12;
          default: b = 8'($urandom);
        endcase
        step(1'($urandom_range(0, 3) != 0), b);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
